// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the IR transmitter and its companion receiver.
//   ir_state_t  - transmitter FSM states
//   IR_*_W      - default pulse widths in 10 kHz ticks; these match the
//                 receiver's decode thresholds (0: 4..8, 1: >=9, start: >=14)
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_MARK,
    SPACE,
    BIT_MARK,
    DONE
  } ir_state_t;

  // Must stay <= 15 to fit the receiver's 4-bit width counter.
  localparam int IR_START_W = 15;
  localparam int IR_ONE_W   = 11;
  localparam int IR_ZERO_W  = 6;
  localparam int IR_GAP_W   = 4;

endpackage

// File: rtl/ir_transmitter_if.sv
// ir_transmitter_if: frame request handshake plus the IR line.
//   start   - request, sampled when the transmitter is idle or signalling done
//   tx_data - N-bit word, captured on the accepting edge
//   ir_out  - registered IR line, high = mark
//   busy    - frame in progress
//   done    - single-cycle end-of-frame pulse
// Modports: master (requester), slave (transmitter).
interface ir_transmitter_if #(
  parameter int N = 8
) ();

  logic         start;
  logic [N-1:0] tx_data;
  logic         ir_out;
  logic         busy;
  logic         done;

  modport master (
    output start, tx_data,
    input  ir_out, busy, done
  );

  modport slave (
    input  start, tx_data,
    output ir_out, busy, done
  );

endinterface

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: loadable down-counter timing one mark or gap.
//   clk, rst   - tick clock, asynchronous active-high reset
//   load       - load load_value this edge
//   load_value - width in ticks of the next state
//   expired    - high in the last cycle of the loaded width
// Expiry is at count 1, so a load of W gives exactly W cycles of the state.
module ir_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count > W'(1)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/ir_transmitter.sv
// ir_transmitter: pulse-width-coded IR frame transmitter.
// A frame is a start mark, a gap, then one mark+gap per data bit, MSB first.
// A 1 bit is a ONE_W mark, a 0 bit a ZERO_W mark; every gap is GAP_W ticks.
//   IR_TX_CLK - 10 kHz tick clock, rising edge
//   reset     - asynchronous active-high reset, abandons any frame
//   bus       - ir_transmitter_if slave: start/tx_data in; ir_out/busy/done out
// Optional feature macro IR_TX_PARITY_EN: appends an odd-parity bit over
// tx_data after the LSB, coded as an ordinary data-bit mark plus gap.
module ir_transmitter
  import ir_pkg::*;
#(
  parameter int N       = 8,
  parameter int START_W = IR_START_W,
  parameter int ONE_W   = IR_ONE_W,
  parameter int ZERO_W  = IR_ZERO_W,
  parameter int GAP_W   = IR_GAP_W
) (
  input logic              IR_TX_CLK,
  input logic              reset,
  ir_transmitter_if.slave  bus
);

  if (!(ZERO_W < ONE_W && ONE_W < START_W && GAP_W >= 1)) begin : g_param_check
    $fatal(1, "ir_transmitter: widths need ZERO_W < ONE_W < START_W and GAP_W >= 1");
  end

  localparam int unsigned TW = $clog2(START_W + 1);
  localparam int unsigned BW = $clog2(N + 2);

`ifdef IR_TX_PARITY_EN
  localparam int unsigned NBITS = N + 1;
`else
  localparam int unsigned NBITS = N;
`endif

  ir_state_t        state;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] captured;
  logic [BW-1:0]    bit_cnt;
  logic             ir_out_q;
  logic             busy_q;
  logic             done_q;

  logic             tmr_load;
  logic [TW-1:0]    tmr_value;
  logic             tmr_expired;

`ifdef IR_TX_PARITY_EN
  // Odd parity: the parity bit makes the total count of ones odd.
  assign captured = {bus.tx_data, ~^bus.tx_data};
`else
  assign captured = bus.tx_data;
`endif

  ir_pulse_timer #(
    .W (TW)
  ) u_timer (
    .clk        (IR_TX_CLK),
    .rst        (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  // Timer reload is decoded from the same conditions as the FSM transitions,
  // so the new width is in place for the first cycle of the next state.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = TW'(START_W);
    case (state)
      IDLE, DONE: begin
        tmr_load  = bus.start;
        tmr_value = TW'(START_W);
      end
      START_MARK, BIT_MARK: begin
        tmr_load  = tmr_expired;
        tmr_value = TW'(GAP_W);
      end
      SPACE: begin
        tmr_load  = tmr_expired && (bit_cnt != '0);
        tmr_value = shreg[NBITS-1] ? TW'(ONE_W) : TW'(ZERO_W);
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = TW'(START_W);
      end
    endcase
  end

  always_ff @(posedge IR_TX_CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      ir_out_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE, giving back-to-back frames.
        IDLE, DONE: begin
          if (bus.start) begin
            shreg    <= captured;
            bit_cnt  <= BW'(NBITS);
            state    <= START_MARK;
            ir_out_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        START_MARK: begin
          if (tmr_expired) begin
            state    <= SPACE;
            ir_out_q <= 1'b0;
          end
        end
        SPACE: begin
          if (tmr_expired) begin
            if (bit_cnt != '0) begin
              state    <= BIT_MARK;
              ir_out_q <= 1'b1;
            end else begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        BIT_MARK: begin
          if (tmr_expired) begin
            shreg    <= shreg << 1;
            bit_cnt  <= bit_cnt - BW'(1);
            state    <= SPACE;
            ir_out_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ir_out_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ir_out = ir_out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_ir_transmitter.sv
// tb_ir_transmitter: self-checking bench for ir_transmitter.
// The reference model lists the expected mark/gap run lengths of a frame
// straight from the coding rules; the monitor measures run lengths on ir_out
// while busy is high and compares them, along with frame length and done.
module tb_ir_transmitter;
  import ir_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ir_transmitter_if #(.N(N)) bus ();

  ir_transmitter #(
    .N       (N),
    .START_W (IR_START_W),
    .ONE_W   (IR_ONE_W),
    .ZERO_W  (IR_ZERO_W),
    .GAP_W   (IR_GAP_W)
  ) dut (
    .IR_TX_CLK (clk),
    .reset     (reset),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_segs[$];
  int exp_len;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected run lengths: start mark, gap, then mark/gap per bit MSB first.
  function automatic void build_model(input logic [N-1:0] d);
    int ones;
    exp_segs.delete();
    exp_segs.push_back(IR_START_W);
    exp_segs.push_back(IR_GAP_W);
    ones = 0;
    for (int i = N - 1; i >= 0; i--) begin
      exp_segs.push_back(d[i] ? IR_ONE_W : IR_ZERO_W);
      exp_segs.push_back(IR_GAP_W);
      if (d[i]) ones++;
    end
`ifdef IR_TX_PARITY_EN
    exp_segs.push_back((ones % 2 == 0) ? IR_ONE_W : IR_ZERO_W);
    exp_segs.push_back(IR_GAP_W);
`endif
    exp_len = 0;
    foreach (exp_segs[i]) exp_len += exp_segs[i];
  endfunction

  task automatic start_frame(input logic [N-1:0] d, input bit hold);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.tx_data = d;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Called right after the accepting edge. pulse_at>0 raises start with other
  // data for one cycle mid-frame. hold keeps start high and presents next_d
  // during the done cycle for a back-to-back frame.
  task automatic observe_frame(input string name, input logic [N-1:0] d,
                               input int pulse_at, input bit hold,
                               input logic [N-1:0] next_d);
    int   obs[$];
    int   run;
    int   blen;
    int   cyc;
    logic cur;
    bit   ended;
    build_model(d);
    run = 0; blen = 0; cyc = 0; cur = 1'b1; ended = 1'b0;
    while (!ended && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check_eq({name, ".first_busy"}, 32'(bus.busy), 32'd1);
        check_eq({name, ".first_mark"}, 32'(bus.ir_out), 32'd1);
      end
      if (bus.busy === 1'b1) begin
        blen++;
        if (bus.ir_out === cur) run++;
        else begin
          obs.push_back(run);
          cur = bus.ir_out;
          run = 1;
        end
      end else begin
        obs.push_back(run);
        ended = 1'b1;
        check_eq({name, ".done"}, 32'(bus.done), 32'd1);
        check_eq({name, ".done_line_low"}, 32'(bus.ir_out), 32'd0);
      end
      if (!hold) begin
        if (cyc == pulse_at) begin
          bus.start   = 1'b1;
          bus.tx_data = ~d;
        end else begin
          bus.start   = 1'b0;
          bus.tx_data = N'($urandom);
        end
      end else begin
        bus.tx_data = ended ? next_d : N'($urandom);
      end
    end
    if (!ended) check_eq({name, ".timeout"}, 32'(cyc), 32'(exp_len + 1));
    check_eq({name, ".busy_len"}, 32'(blen), 32'(exp_len));
    check_eq({name, ".seg_count"}, 32'(obs.size()), 32'(exp_segs.size()));
    for (int i = 0; i < obs.size() && i < exp_segs.size(); i++)
      check_eq($sformatf("%s.seg%0d", name, i), 32'(obs[i]), 32'(exp_segs[i]));
    if (!hold) begin
      @(negedge clk);
      check_eq({name, ".done_single"}, 32'(bus.done), 32'd0);
      check_eq({name, ".idle_busy"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    logic [N-1:0] d;
    int           p;
    int           seen_ir, seen_busy, seen_done;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: nothing moves for 50 cycles.
    seen_ir = 0; seen_busy = 0; seen_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.ir_out !== 1'b0) seen_ir++;
      if (bus.busy !== 1'b0) seen_busy++;
      if (bus.done !== 1'b0) seen_done++;
    end
    check_eq("idle.ir_out", 32'(seen_ir), 32'd0);
    check_eq("idle.busy", 32'(seen_busy), 32'd0);
    check_eq("idle.done", 32'(seen_done), 32'd0);

    // Directed words.
    start_frame(8'hA5, 1'b0); observe_frame("a5", 8'hA5, 0, 1'b0, '0);
    start_frame(8'h00, 1'b0); observe_frame("x00", 8'h00, 0, 1'b0, '0);
    start_frame(8'hFF, 1'b0); observe_frame("xff", 8'hFF, 0, 1'b0, '0);
    start_frame(8'h01, 1'b0); observe_frame("x01", 8'h01, 0, 1'b0, '0);

    // start mid-frame with different data is ignored.
    start_frame(8'hA5, 1'b0); observe_frame("midstart", 8'hA5, 40, 1'b0, '0);

    // start held across done: next frame starts with no idle cycle.
    start_frame(8'h3C, 1'b1);
    observe_frame("b2b_first", 8'h3C, 0, 1'b1, 8'hC3);
    observe_frame("b2b_second", 8'hC3, 0, 1'b0, '0);

    // Reset during the first bit mark (0x96 MSB=1, mark in cycles 20..30).
    start_frame(8'h96, 1'b0);
    repeat (22) @(negedge clk);
    check_eq("rst.pre_mark", 32'(bus.ir_out), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst.ir_out", 32'(bus.ir_out), 32'd0);
    check_eq("rst.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_busy = 0; seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) seen_busy++;
      if (bus.done !== 1'b0) seen_done++;
    end
    check_eq("rst.no_done", 32'(seen_done), 32'd0);
    check_eq("rst.no_busy", 32'(seen_busy), 32'd0);
    start_frame(8'h5E, 1'b0); observe_frame("after_rst", 8'h5E, 0, 1'b0, '0);

    // Random words, random mid-frame start pulses, random idle spacing.
    for (int k = 0; k < 8; k++) begin
      d = N'($urandom);
      p = (($urandom % 2) == 0) ? 0 : int'($urandom_range(2, 90));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_frame(d, 1'b0);
      observe_frame($sformatf("rand%0d", k), d, p, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_transmitter.md
# ir_transmitter

Serial IR frame transmitter: accepts an N-bit word through a start/busy/done handshake and drives a demodulated, pulse-width-coded IR line. One start mark is followed by one mark per data bit, each mark followed by a low gap. Default widths match the team's IR receiver thresholds on the 10 kHz IR clock:
- 0 bit: ≥4 and <9 ticks
- 1 bit: ≥9 ticks
- start: ≥14 ticks

The block sits in the main top module beside the receiver, clocked by the same 10 kHz tick domain.

## Interface
Parameters:
- N, 8: data bits per frame
- START_W, 15: start mark width, ticks; must be ≤15 to survive the receiver's 4-bit width counter
- ONE_W, 11: mark width for a 1 bit
- ZERO_W, 6: mark width for a 0 bit
- GAP_W, 4: low gap after every mark

Ports:
- IR_TX_CLK  in  1  10 kHz tick clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only when idle or when done=1
- tx_data  in  N  word to send; captured on the accepting edge
- ir_out  out  1  registered IR line; high = mark
- busy  out  1  frame in progress
- done  out  1  single-cycle end-of-frame pulse

## Operation
- All outputs reset to 0; FSM resets to IDLE.
- FSM states and transitions:
  - IDLE: on start=1, capture tx_data into a shift register, load timer with START_W, go to START_MARK.
  - START_MARK: ir_out=1; on expiry load GAP_W, go to SPACE.
  - SPACE: ir_out=0. On expiry:
    - bits remain: load ONE_W or ZERO_W per current MSB, go to BIT_MARK.
    - no bits remain: go to DONE.
  - BIT_MARK: ir_out=1; on expiry shift the word left by one, decrement the bit count, load GAP_W, go to SPACE.
  - DONE: done=1 and busy=0 for one cycle. If start=1 in this cycle, accept it exactly as in IDLE (back-to-back frames); otherwise go to IDLE.
- Data is sent MSB first.
- Timer: down-counter loaded with width W; expires when it reaches 1, so a state lasts exactly W cycles.
- Counter widths:
  - timer: $clog2(START_W+1) bits.
  - bit counter: $clog2(N+2) bits, enough for N+1.
- Parameters must satisfy ZERO_W < ONE_W < START_W and GAP_W ≥ 1; violations are a fatal elaboration error.
- start while busy=1 is ignored; tx_data changes after capture have no effect.
- Reset mid-frame: ir_out drops low asynchronously, the frame is abandoned and no done is produced.

## Timing
- Accept on edge k → ir_out=1 and busy=1 from cycle k+1.
- Frame length L = START_W + GAP_W + Σ(mark_i + GAP_W). busy stays high for exactly L cycles.
- done=1 in cycle k+1+L, the first cycle with busy=0.
- ir_out, busy and done are all registered; none is combinational from inputs.

## Configuration
- IR_TX_PARITY_EN defined:
  - An odd-parity bit over tx_data is sent as bit N+1, encoded as a normal mark plus gap, after the LSB.
  - L grows by (ONE_W or ZERO_W) + GAP_W.
- Undefined: exactly N bits are sent; no parity logic is present.

## Structure
- Package ir_pkg:
  - FSM state enum (IDLE, START_MARK, SPACE, BIT_MARK, DONE).
  - Default width constants IR_START_W, IR_ONE_W, IR_ZERO_W, IR_GAP_W, shared with the receiver.
- Sub-module ir_pulse_timer:
  - Ports: load, load value, expired flag.
  - Parameterised width.
  - Instantiated once.

## Test plan
- Reset with no start → ir_out, busy, done stay 0 for 50 cycles.
- start with tx_data=8'hA5, parity off → marks 15,11,6,11,6,6,11,6,11 separated by 4-cycle gaps. busy high 119 cycles, done in cycle 120 after accept.
- tx_data=8'h00 then 8'hFF → L=99 and L=139 respectively. Mark widths all 6 / all 11.
- start pulsed mid-frame with different data → ignored; frame and length unchanged.
- start held high across done → second frame's start mark begins the cycle after done, with no idle cycle.
- reset asserted during BIT_MARK → ir_out low immediately, no done. The next start sends a complete, correct frame.
- IR_TX_PARITY_EN defined, tx_data=8'h01 → a ZERO_W mark (parity 0) follows the LSB mark, and L grows by ZERO_W+GAP_W.
